clock_mode_ctrl: RTL and testbench

Mode/setting controller for the MM:SS clock. Sits between `btn_in`/`cnt1sec` and the two `cnt60` counters. Decides whether the counters run from the 1 Hz enable or are frozen for manual adjustment, and routes up/down button pulses to the selected counter's INC/DEC. It also generates per-digit blanking so the digit pair being set blinks on the 7-segment display.

---
 rtl/clock_mode_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_clock_mode_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clock_mode_ctrl                                              |
// | Description : RUN / SET_MIN / SET_SEC controller for the MM:SS clock.      |
// |               Gates the cnt60 enables, routes up/down presses to INC/DEC,  |
// |               blinks the digit pair being set and drops back to RUN on an  |
// |               idle timeout. Optional button auto-repeat is built when      |
// |               CLOCK_MODE_CTRL_AUTOREPEAT_EN is defined.                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module clock_mode_ctrl #(
    parameter int BLINK_TICKS  = 5,
    parameter int REPEAT_DELAY = 5,
    parameter int REPEAT_RATE  = 2,
    parameter int TIMEOUT_SEC  = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en1hz,
    input  logic       tick,
    input  logic       mode_p,
    input  logic       up_p,
    input  logic       down_p,
    input  logic       up_lvl,
    input  logic       down_lvl,
    input  logic       carry_sec,
    output logic       sec_cen,
    output logic       sec_inc,
    output logic       sec_dec,
    output logic       min_cen,
    output logic       min_inc,
    output logic       min_dec,
    output logic [3:0] blank,
    output logic [1:0] mode
);

    localparam logic [1:0] c_st_run     = 2'b00;
    localparam logic [1:0] c_st_set_min = 2'b01;
    localparam logic [1:0] c_st_set_sec = 2'b10;

    localparam int c_blink_w = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'((BLINK_TICKS > 0) ? BLINK_TICKS - 1 : 0);

    localparam int c_to_w = (TIMEOUT_SEC > 1) ? $clog2(TIMEOUT_SEC) : 1;
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'((TIMEOUT_SEC > 0) ? TIMEOUT_SEC - 1 : 0);
    localparam logic c_to_enabled = (TIMEOUT_SEC != 0);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic                 w_set;
    logic                 w_timeout;
    logic                 w_state_chg;
    logic                 w_activity;
    logic                 w_rep_step;
    logic                 w_rep_up;
    logic                 w_rep_dn;
    logic                 w_up_req;
    logic                 w_dn_req;
    logic                 w_up_step;
    logic                 w_dn_step;
    logic                 w_blink_clr;
    logic                 w_phase_nxt;
    logic [c_blink_w-1:0] w_blink_cnt_nxt;
    logic [3:0]           w_blank_nxt;

    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_phase;
    logic [c_to_w-1:0]    r_to_cnt;
    logic                 r_sec_cen;
    logic                 r_sec_inc;
    logic                 r_sec_dec;
    logic                 r_min_cen;
    logic                 r_min_inc;
    logic                 r_min_dec;
    logic [3:0]           r_blank;

    // Encoding 11 is treated as RUN everywhere.
    assign w_set       = (r_state == c_st_set_min) || (r_state == c_st_set_sec);
    assign w_activity  = mode_p | up_p | down_p | w_rep_step;
    assign w_timeout   = c_to_enabled & w_set & en1hz & ~w_activity & (r_to_cnt == c_to_last);
    assign w_state_chg = mode_p | w_timeout;

    // mode_p wins over any coincident step request.
    assign w_up_req  = w_set & ~mode_p & (up_p | w_rep_up);
    assign w_dn_req  = w_set & ~mode_p & (down_p | w_rep_dn);
    assign w_up_step = w_up_req & ~w_dn_req;
    assign w_dn_step = w_dn_req & ~w_up_req;

`ifdef CLOCK_MODE_CTRL_AUTOREPEAT_EN
    localparam int c_rep_max = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_hold_w  = (c_rep_max > 1) ? $clog2(c_rep_max) : 1;
    localparam logic [c_hold_w-1:0] c_delay_last = c_hold_w'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [c_hold_w-1:0] c_rate_last  = c_hold_w'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);

    logic [c_hold_w-1:0] r_hold_cnt;
    logic                r_repeating;
    logic                w_hold_lvl;

    assign w_hold_lvl = w_set & (up_lvl ^ down_lvl);
    assign w_rep_step = w_hold_lvl & tick &
                        ((~r_repeating & (r_hold_cnt == c_delay_last)) |
                         ( r_repeating & (r_hold_cnt == c_rate_last)));
    assign w_rep_up   = w_rep_step & up_lvl;
    assign w_rep_dn   = w_rep_step & down_lvl;

    // First step after REPEAT_DELAY ticks, then one every REPEAT_RATE ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_cnt  <= '0;
            r_repeating <= 1'b0;
        end else if (!w_hold_lvl || w_state_chg) begin
            r_hold_cnt  <= '0;
            r_repeating <= 1'b0;
        end else if (tick) begin
            if (w_rep_step) begin
                r_hold_cnt  <= '0;
                r_repeating <= 1'b1;
            end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end
`else
    logic w_unused_lvl;

    assign w_unused_lvl = up_lvl ^ down_lvl;
    assign w_rep_step   = 1'b0;
    assign w_rep_up     = 1'b0;
    assign w_rep_dn     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (mode_p) begin
            case (r_state)
                c_st_set_min: w_state_nxt = c_st_set_sec;
                c_st_set_sec: w_state_nxt = c_st_run;
                default:      w_state_nxt = c_st_set_min;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = c_st_run;
        end
    end

    assign w_blink_clr = ~w_set | w_state_chg | up_p | down_p | w_rep_step;

    always_comb begin
        w_phase_nxt     = r_phase;
        w_blink_cnt_nxt = r_blink_cnt;
        if (w_blink_clr) begin
            w_phase_nxt     = 1'b0;
            w_blink_cnt_nxt = '0;
        end else if (tick) begin
            if (r_blink_cnt == c_blink_last) begin
                w_phase_nxt     = ~r_phase;
                w_blink_cnt_nxt = '0;
            end else begin
                w_blink_cnt_nxt = r_blink_cnt + 1'b1;
            end
        end
    end

    // Blank follows the next phase so a press un-blanks on the very next cycle.
    always_comb begin
        w_blank_nxt = 4'b0000;
        case (r_state)
            c_st_set_min: w_blank_nxt = {w_phase_nxt, w_phase_nxt, 2'b00};
            c_st_set_sec: w_blank_nxt = {2'b00, w_phase_nxt, w_phase_nxt};
            default:      w_blank_nxt = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else begin
            r_blink_cnt <= w_blink_cnt_nxt;
            r_phase     <= w_phase_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (!w_set || w_activity || w_state_chg) begin
            r_to_cnt <= '0;
        end else if (en1hz && c_to_enabled) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sec_cen <= 1'b0;
            r_sec_inc <= 1'b0;
            r_sec_dec <= 1'b0;
            r_min_cen <= 1'b0;
            r_min_inc <= 1'b0;
            r_min_dec <= 1'b0;
            r_blank   <= 4'b0000;
        end else begin
            r_sec_cen <= ~w_set & en1hz;
            r_min_cen <= ~w_set & carry_sec;
            r_sec_inc <= (r_state == c_st_set_sec) & w_up_step;
            r_sec_dec <= (r_state == c_st_set_sec) & w_dn_step;
            r_min_inc <= (r_state == c_st_set_min) & w_up_step;
            r_min_dec <= (r_state == c_st_set_min) & w_dn_step;
            r_blank   <= w_blank_nxt;
        end
    end

    assign sec_cen = r_sec_cen;
    assign sec_inc = r_sec_inc;
    assign sec_dec = r_sec_dec;
    assign min_cen = r_min_cen;
    assign min_inc = r_min_inc;
    assign min_dec = r_min_dec;
    assign blank   = r_blank;
    assign mode    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_clock_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_clock_mode_ctrl                                           |
// | Description : Table-driven bench for clock_mode_ctrl plus hand sequences   |
// |               for blink, timeout, auto-repeat and async reset.             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_clock_mode_ctrl;

`ifdef CLOCK_MODE_CTRL_AUTOREPEAT_EN
    localparam bit c_ar = 1'b1;
`else
    localparam bit c_ar = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en1hz = 1'b0, tick = 1'b0, mode_p = 1'b0, up_p = 1'b0, down_p = 1'b0;
    logic       up_lvl = 1'b0, down_lvl = 1'b0, carry_sec = 1'b0;
    logic       sec_cen, sec_inc, sec_dec, min_cen, min_inc, min_dec;
    logic [3:0] blank;
    logic [1:0] mode;
    logic [5:0] w_ctl;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    clock_mode_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .en1hz     (en1hz),
        .tick      (tick),
        .mode_p    (mode_p),
        .up_p      (up_p),
        .down_p    (down_p),
        .up_lvl    (up_lvl),
        .down_lvl  (down_lvl),
        .carry_sec (carry_sec),
        .sec_cen   (sec_cen),
        .sec_inc   (sec_inc),
        .sec_dec   (sec_dec),
        .min_cen   (min_cen),
        .min_inc   (min_inc),
        .min_dec   (min_dec),
        .blank     (blank),
        .mode      (mode)
    );

    assign w_ctl = {sec_cen, sec_inc, sec_dec, min_cen, min_inc, min_dec};

    // ctl = {sec_cen, sec_inc, sec_dec, min_cen, min_inc, min_dec}
    typedef struct {
        logic       en1hz;
        logic       tick;
        logic       mode_p;
        logic       up_p;
        logic       down_p;
        logic       carry;
        logic [5:0] ctl;
        logic [3:0] blank;
        logic [1:0] mode;
    } vec_t;

    vec_t vt [21];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        en1hz = 1'b0; tick = 1'b0; mode_p = 1'b0; up_p = 1'b0; down_p = 1'b0; carry_sec = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctl"},   8'(w_ctl), 8'd0);
        chk({nm, "_blank"}, 8'(blank), 8'd0);
        chk({nm, "_mode"},  8'(mode),  8'd0);
    endtask

    task automatic press_mode();
        mode_p = 1'b1;
        step();
        mode_p = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got no end expected end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //           en  tk  md  up  dn  ca  ctl        blank    mode
        vt[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,6'b000000,4'b0000,2'b00};
        vt[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,6'b100000,4'b0000,2'b00};
        vt[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,6'b000000,4'b0000,2'b00};
        vt[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,6'b100100,4'b0000,2'b00};
        vt[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,6'b100000,4'b0000,2'b00};
        vt[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,6'b000100,4'b0000,2'b00};
        vt[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,6'b000000,4'b0000,2'b00};
        vt[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,6'b000000,4'b0000,2'b00};
        vt[8]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,6'b000000,4'b0000,2'b01};
        vt[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,6'b000010,4'b0000,2'b01};
        vt[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,6'b000000,4'b0000,2'b01};
        vt[11] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,6'b000010,4'b0000,2'b01};
        vt[12] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,6'b000010,4'b0000,2'b01};
        vt[13] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,6'b000001,4'b0000,2'b01};
        vt[14] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,6'b000000,4'b0000,2'b01};
        vt[15] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,6'b000000,4'b0000,2'b10};
        vt[16] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,6'b010000,4'b0000,2'b10};
        vt[17] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,6'b001000,4'b0000,2'b10};
        vt[18] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,6'b000000,4'b0000,2'b10};
        vt[19] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,6'b000000,4'b0000,2'b00};
        vt[20] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,6'b100000,4'b0000,2'b00};

        // Reset state
        rst = 1'b1;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();
        chk_all_zero("post_reset");

        for (int i = 0; i < 21; i++) begin
            en1hz     = vt[i].en1hz;
            tick      = vt[i].tick;
            mode_p    = vt[i].mode_p;
            up_p      = vt[i].up_p;
            down_p    = vt[i].down_p;
            carry_sec = vt[i].carry;
            step();
            chk($sformatf("vec%0d_ctl", i),   8'(w_ctl), 8'(vt[i].ctl));
            chk($sformatf("vec%0d_blank", i), 8'(blank), 8'(vt[i].blank));
            chk($sformatf("vec%0d_mode", i),  8'(mode),  8'(vt[i].mode));
            clr_in();
        end

        // Blink in SET_SEC, then a press mid-blank forces digits visible.
        press_mode();
        press_mode();
        chk("blink_enter_mode", 8'(mode), 8'd2);
        for (int k = 1; k <= 7; k++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            chk($sformatf("blink_tick%0d", k), 8'(blank), ((k / 5) % 2 == 1) ? 8'h03 : 8'h00);
            step();
        end
        up_p = 1'b1;
        step();
        up_p = 1'b0;
        chk("blink_press_blank", 8'(blank), 8'h00);
        chk("blink_press_inc", 8'(sec_inc), 8'd1);
        step();
        chk("inc_single_cycle", 8'(sec_inc), 8'd0);
        for (int k = 1; k <= 5; k++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            chk($sformatf("reblink_tick%0d", k), 8'(blank), (k == 5) ? 8'h03 : 8'h00);
        end

        // Asynchronous reset while blanked.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst_blink");
        step();
        rst = 1'b0;
        step();
        chk_all_zero("after_rst_blink");
        for (int k = 1; k <= 5; k++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
        end
        chk("run_no_blink", 8'(blank), 8'h00);

        // SET_MIN blink and idle timeout.
        press_mode();
        chk("to_enter_mode", 8'(mode), 8'd1);
        for (int k = 1; k <= 5; k++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
        end
        chk("setmin_blank", 8'(blank), 8'h0C);
        for (int k = 1; k <= 29; k++) begin
            en1hz = 1'b1;
            step();
            en1hz = 1'b0;
            chk($sformatf("to_frozen%0d", k), 8'(sec_cen), 8'd0);
            step();
        end
        chk("to_before_expiry", 8'(mode), 8'd1);
        en1hz = 1'b1;
        step();
        en1hz = 1'b0;
        chk("to_expired_mode", 8'(mode), 8'd0);
        chk("to_expired_blank", 8'(blank), 8'h00);
        en1hz = 1'b1;
        step();
        en1hz = 1'b0;
        chk("to_resume_cen", 8'(sec_cen), 8'd1);

        // mode_p on the 30th pulse wins over expiry.
        press_mode();
        for (int k = 1; k <= 29; k++) begin
            en1hz = 1'b1;
            step();
            en1hz = 1'b0;
            step();
        end
        en1hz = 1'b1;
        mode_p = 1'b1;
        step();
        clr_in();
        chk("to_mode_priority", 8'(mode), 8'd2);
        for (int k = 1; k <= 29; k++) begin
            en1hz = 1'b1;
            step();
            en1hz = 1'b0;
            step();
        end
        chk("to_counter_cleared", 8'(mode), 8'd2);
        en1hz = 1'b1;
        step();
        en1hz = 1'b0;
        chk("to_second_expiry", 8'(mode), 8'd0);

        // Held up button in SET_SEC: repeats only when auto-repeat is built.
        press_mode();
        press_mode();
        up_lvl = 1'b1;
        up_p   = 1'b1;
        step();
        up_p = 1'b0;
        chk("hold_first_inc", 8'(sec_inc), 8'd1);
        step();
        for (int k = 1; k <= 12; k++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            chk($sformatf("hold_tick%0d", k), 8'(sec_inc),
                (c_ar && k >= 5 && k <= 11 && (k % 2) == 1) ? 8'd1 : 8'd0);
            step();
            chk($sformatf("hold_gap%0d", k), 8'(sec_inc), 8'd0);
        end
        tick = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst_hold");
        step();
        tick   = 1'b0;
        up_lvl = 1'b0;
        rst    = 1'b0;
        step();
        chk_all_zero("after_rst_hold");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
